// File: rtl/wash_timer.sv
// Washing-machine countdown controller: three debounced pushbuttons drive an
// OFF/IDLE/RUN/PAUSE/DONE FSM that counts the selected program time down.
module wash_timer #(
    parameter int TICK_DIV  = 100000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_btn,
    input  logic       start_btn,
    input  logic       mode_btn,
    output logic       power_light,
    output logic [6:0] total_time,
    output logic [6:0] current_time,
    output logic [2:0] current_water,
    output logic       running,
    output logic       done
);
    localparam int PW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {S_OFF, S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    // Button vectors are indexed 0=power, 1=start, 2=mode.
    logic [2:0]           sync1_q, sync2_q;
    logic [2:0]           level_q, level_d;
    logic [2:0]           prev_q;
    logic [2:0]           armed_q, armed_d;
    logic [2:0][DBW-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]           settle_q, settle_d;
    logic [2:0]           press;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d, next_mode;
    logic [PW-1:0]   presc_q, presc_d;
    logic [6:0]      total_q, total_d;
    logic [6:0]      cur_q, cur_d;
    logic [2:0]      water_q, water_d;
    logic            tick;

    function automatic logic [6:0] prog_time(input logic [1:0] m);
        case (m)
            2'd0:    return 7'd15;
            2'd1:    return 7'd30;
            2'd2:    return 7'd45;
            default: return 7'd90;
        endcase
    endfunction

    function automatic logic [2:0] prog_water(input logic [1:0] m);
        case (m)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            2'd2:    return 3'd3;
            default: return 3'd5;
        endcase
    endfunction

    // A button must be seen released after reset before it may generate
    // presses, so a button held through reset never fires.
    always_comb begin
        level_d  = level_q;
        armed_d  = armed_q;
        db_cnt_d = '0;
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
            if (settle_q == 2'd2 && !sync2_q[i] && !level_q[i]) begin
                armed_d[i] = 1'b1;
            end
        end
    end

    assign press = level_q & ~prev_q & armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '0;
            prev_q   <= '0;
            armed_q  <= '0;
            db_cnt_q <= '0;
            settle_q <= '0;
        end else begin
            sync1_q  <= {mode_btn, start_btn, power_btn};
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            prev_q   <= level_q;
            armed_q  <= armed_d;
            db_cnt_q <= db_cnt_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        presc_d   = presc_q;
        total_d   = total_q;
        cur_d     = cur_q;
        water_d   = water_q;
        next_mode = mode_q + 2'd1;
        tick      = (presc_q == PRESC_MAX);
        case (state_q)
            S_OFF: begin
                if (press[0]) begin
                    state_d = S_IDLE;
                    total_d = prog_time(2'd0);
                    cur_d   = prog_time(2'd0);
                    water_d = prog_water(2'd0);
                end
            end
            S_IDLE: begin
                if (press[0]) begin
                    state_d = S_OFF;
                end else if (press[1]) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end else if (press[2]) begin
                    mode_d  = next_mode;
                    total_d = prog_time(next_mode);
                    cur_d   = prog_time(next_mode);
                    water_d = prog_water(next_mode);
                end
            end
            S_RUN: begin
                if (press[0]) begin
                    state_d = S_OFF;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick && cur_q != 7'd0) begin
                        cur_d = cur_q - 7'd1;
                    end
                    // Reaching zero wins over a simultaneous start press.
                    if (tick && cur_q <= 7'd1) begin
                        state_d = S_DONE;
                    end else if (press[1]) begin
                        state_d = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (press[0]) begin
                    state_d = S_OFF;
                end else if (press[1]) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (press[0]) begin
                    state_d = S_OFF;
                end else if (press[1]) begin
                    state_d = S_IDLE;
                    cur_d   = total_q;
                end
            end
            default: state_d = S_OFF;
        endcase
        if (state_d == S_OFF) begin
            mode_d  = '0;
            presc_d = '0;
            total_d = '0;
            cur_d   = '0;
            water_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            mode_q      <= '0;
            presc_q     <= '0;
            total_q     <= '0;
            cur_q       <= '0;
            water_q     <= '0;
            power_light <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            total_q     <= total_d;
            cur_q       <= cur_d;
            water_q     <= water_d;
            power_light <= (state_d != S_OFF);
            running     <= (state_d == S_RUN);
            done        <= (state_d == S_DONE);
        end
    end

    assign total_time    = total_q;
    assign current_time  = cur_q;
    assign current_water = water_q;

endmodule
